// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
package key_debounce_pkg;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } ch_state_e;

endpackage

// File: rtl/key_debounce_if.sv
// Key bundle: raw active-low buttons in, debounced level/pulses/toggle out.
interface key_debounce_if #(parameter int N = 1);

    logic [N-1:0] key_raw;
    logic [N-1:0] key_level;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] key_toggle;

    modport master (output key_raw, input key_level, key_press, key_release, key_toggle);
    modport slave  (input key_raw, output key_level, key_press, key_release, key_toggle);

endinterface

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, qualification counter, FSM,
// registered press/release pulses and press toggle.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    key_debounce_if.slave kif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          s;
    ch_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          toggle_q, toggle_d;

    // Synchronizer resets to 1 so a held key after reset is seen as a fresh press
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], kif.key_raw[0]};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign s = ~sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        toggle_d = toggle_q ^ press_d;
    end

    assign kif.key_level[0]   = (state_q == HELD) || (state_q == RELEASE_WAIT);
    assign kif.key_press[0]   = press_q;
    assign kif.key_release[0] = release_q;
    assign kif.key_toggle[0]  = toggle_q;

endmodule

// File: rtl/key_debounce.sv
// NUM_KEYS independent debounce channels for active-low board push-buttons.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_toggle
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_if #(.N(1)) ch_if ();

        assign ch_if.key_raw[0] = key_raw[g];
        assign key_level[g]     = ch_if.key_level[0];
        assign key_press[g]     = ch_if.key_press[0];
        assign key_release[g]   = ch_if.key_release[0];
        assign key_toggle[g]    = ch_if.key_toggle[0];

        key_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .kif     (ch_if.slave)
        );
    end

endmodule
